parking_occupancy_ctrl: RTL and testbench

Parametrised multi-gate occupancy controller for the car-park design. Each of NUM_GATES gates has an A/B sensor pair and its own direction-detect FSM that classifies a pass as an entry or an exit. A shared saturating counter tracks occupancy against CAPACITY and drives full/empty flags. It replaces the fixed single-entry/single-exit FSM pair and its 8-bit counter.

---
 rtl/parking_occupancy_ctrl.sv | 159 +++++++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - multi-gate A/B direction detect with saturating occupancy counter
// Optional sticky err output enabled by defining PARK_OCC_ERR_EN.
module parking_occupancy_ctrl #(
    parameter int NUM_GATES = 2,
    parameter int COUNT_W   = 8,
    parameter int CAPACITY  = 200,
    parameter int TIMEOUT   = 1000,
    parameter int TO_W      = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_GATES-1:0] sens_a,
    input  logic [NUM_GATES-1:0] sens_b,
    output logic [COUNT_W-1:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic [NUM_GATES-1:0] enter_pulse,
    output logic [NUM_GATES-1:0] exit_pulse
`ifdef PARK_OCC_ERR_EN
    ,
    output logic                 err
`endif
);
    localparam int PW = $clog2(NUM_GATES + 1);
    localparam int SW = COUNT_W + PW + 1;

    typedef enum logic [2:0] {IDLE, ARM_IN, IN_B, ARM_OUT, OUT_A} state_t;

    state_t               state  [NUM_GATES];
    logic [TO_W-1:0]      to_cnt [NUM_GATES];
    logic [NUM_GATES-1:0] a_q, b_q, a_d, b_d, a_rise, b_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            a_d <= '0;
            b_d <= '0;
        end else begin
            a_q <= sens_a;
            b_q <= sens_b;
            a_d <= a_q;
            b_d <= b_q;
        end
    end

    assign a_rise = a_q & ~a_d;
    assign b_rise = b_q & ~b_d;

    // Simultaneous rises fail both IDLE tests because the other sensor is already high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_pulse <= '0;
            exit_pulse  <= '0;
            for (int g = 0; g < NUM_GATES; g++) begin
                state[g]  <= IDLE;
                to_cnt[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_GATES; g++) begin
                enter_pulse[g] <= 1'b0;
                exit_pulse[g]  <= 1'b0;
                case (state[g])
                    IDLE: begin
                        if (a_rise[g] && !b_q[g]) begin
                            state[g]  <= ARM_IN;
                            to_cnt[g] <= '0;
                        end else if (b_rise[g] && !a_q[g]) begin
                            state[g]  <= ARM_OUT;
                            to_cnt[g] <= '0;
                        end
                    end
                    ARM_IN: begin
                        if (b_q[g]) begin
                            state[g] <= IN_B;
                        end else if (to_cnt[g] == TO_W'(TIMEOUT - 1)) begin
                            state[g] <= IDLE;
                        end else begin
                            to_cnt[g] <= to_cnt[g] + 1'b1;
                        end
                    end
                    IN_B: begin
                        if (!b_q[g] && !a_q[g]) begin
                            enter_pulse[g] <= 1'b1;
                            state[g]       <= IDLE;
                        end
                    end
                    ARM_OUT: begin
                        if (a_q[g]) begin
                            state[g] <= OUT_A;
                        end else if (to_cnt[g] == TO_W'(TIMEOUT - 1)) begin
                            state[g] <= IDLE;
                        end else begin
                            to_cnt[g] <= to_cnt[g] + 1'b1;
                        end
                    end
                    OUT_A: begin
                        if (!a_q[g] && !b_q[g]) begin
                            exit_pulse[g] <= 1'b1;
                            state[g]      <= IDLE;
                        end
                    end
                    default: state[g] <= IDLE;
                endcase
            end
        end
    end

    logic [PW-1:0]      n_in, n_out;
    logic [SW-1:0]      total, diff;
    logic [COUNT_W-1:0] cnt_nxt;
`ifdef PARK_OCC_ERR_EN
    logic               drop;
`endif

    // Net delta is applied first, then the result is clamped, so an entry and exit cancel.
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            n_in  = n_in + PW'(enter_pulse[g]);
            n_out = n_out + PW'(exit_pulse[g]);
        end
        total = SW'(count) + SW'(n_in);
        diff  = total - SW'(n_out);
        if (total < SW'(n_out)) begin
            cnt_nxt = '0;
        end else if (diff > SW'(CAPACITY)) begin
            cnt_nxt = COUNT_W'(CAPACITY);
        end else begin
            cnt_nxt = diff[COUNT_W-1:0];
        end
`ifdef PARK_OCC_ERR_EN
        drop = (total < SW'(n_out)) || (diff > SW'(CAPACITY));
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= cnt_nxt;
        end
    end

`ifdef PARK_OCC_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (drop) begin
            err <= 1'b1;
        end
    end
`endif

    assign full  = (count == COUNT_W'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb/tb_parking_occupancy_ctrl.sv - scoreboard bench for parking_occupancy_ctrl
module tb_parking_occupancy_ctrl;
    localparam int NG  = 2;
    localparam int CW  = 8;
    localparam int CAP = 6;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NG-1:0] sens_a = '0;
    logic [NG-1:0] sens_b = '0;
    logic [CW-1:0] count;
    logic          full, empty;
    logic [NG-1:0] enter_pulse, exit_pulse;
`ifdef PARK_OCC_ERR_EN
    logic          err;
`endif

    parking_occupancy_ctrl #(
        .NUM_GATES(NG), .COUNT_W(CW), .CAPACITY(CAP), .TIMEOUT(TO), .TO_W(5)
    ) dut (
        .clk(clk), .reset(reset), .sens_a(sens_a), .sens_b(sens_b),
        .count(count), .full(full), .empty(empty),
        .enter_pulse(enter_pulse), .exit_pulse(exit_pulse)
`ifdef PARK_OCC_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NG-1:0] en;
        logic [NG-1:0] ex;
        int            cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_cnt = 0;
    bit   model_err = 1'b0;
    bit   pend = 1'b0;
    int   pend_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (pend) begin
                chk("count_after_pulse", 32'(count), pend_cnt);
                chk("full_after_pulse", 32'(full), 32'(pend_cnt == CAP));
                chk("empty_after_pulse", 32'(empty), 32'(pend_cnt == 0));
                pend = 1'b0;
            end
            if ((enter_pulse | exit_pulse) != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'({enter_pulse, exit_pulse}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("enter_pulse", 32'(enter_pulse), 32'(e.en));
                    chk("exit_pulse", 32'(exit_pulse), 32'(e.ex));
                    pend     = 1'b1;
                    pend_cnt = e.cnt;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pass(input logic [NG-1:0] en, input logic [NG-1:0] ex);
        exp_t e;
        int   r;
        r = model_cnt + $countones(en) - $countones(ex);
        if (r > CAP) begin
            r = CAP;
            model_err = 1'b1;
        end else if (r < 0) begin
            r = 0;
            model_err = 1'b1;
        end
        model_cnt = r;
        e.en = en; e.ex = ex; e.cnt = r;
        sb.push_back(e);
        cyc(1); sens_a = en; sens_b = ex;
        cyc(1); sens_a = '0; sens_b = '0;
        cyc(1); sens_a = ex; sens_b = en;
        cyc(1); sens_a = '0; sens_b = '0;
        cyc(6);
        chk("count", 32'(count), model_cnt);
    endtask

    initial begin
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pulses", 32'({enter_pulse, exit_pulse}), 0);
`ifdef PARK_OCC_ERR_EN
        chk("rst_err", 32'(err), 0);
`endif
        cyc(3);
        reset = 1'b1;
        cyc(2);

        pass(2'b01, 2'b00);
        chk("empty_after_entry", 32'(empty), 0);

        for (int i = 0; i < 3; i++) pass(2'b10, 2'b00);
        pass(2'b00, 2'b10);

        pass(2'b01, 2'b00);
        pass(2'b10, 2'b00);
        chk("count_five", 32'(count), 5);
        pass(2'b01, 2'b10);

        pass(2'b01, 2'b00);
        chk("full_at_cap", 32'(full), 1);
        pass(2'b10, 2'b00);
        chk("full_clamped", 32'(full), 1);
`ifdef PARK_OCC_ERR_EN
        chk("err_overflow", 32'(err), 32'(model_err));
`endif

        for (int i = 0; i < CAP; i++) pass(2'b00, 2'b01);
        pass(2'b00, 2'b10);
        chk("empty_clamped", 32'(empty), 1);
`ifdef PARK_OCC_ERR_EN
        chk("err_sticky", 32'(err), 1);
`endif

        pass(2'b01, 2'b00);
        cyc(1); sens_a = 2'b01;
        cyc(1); sens_a = 2'b00;
        cyc(TO + 10);
        chk("timeout_no_event", 32'(count), 1);
        pass(2'b00, 2'b01);

        for (int i = 0; i < 4; i++) pass(2'b01, 2'b00);
        cyc(1); sens_a = 2'b01;
        cyc(1); sens_a = 2'b00;
        cyc(1); sens_b = 2'b01;
        cyc(4);
        reset = 1'b0;
        @(negedge clk);
        chk("midpass_rst_count", 32'(count), 0);
        chk("midpass_rst_empty", 32'(empty), 1);
        chk("midpass_rst_pulse", 32'({enter_pulse, exit_pulse}), 0);
        cyc(2);
        reset = 1'b1;
        model_cnt = 0;
        model_err = 1'b0;
        cyc(3);
        sens_b = 2'b00;
        cyc(TO + 10);
        chk("post_rst_count", 32'(count), 0);
`ifdef PARK_OCC_ERR_EN
        chk("post_rst_err", 32'(err), 0);
`endif
        pass(2'b01, 2'b00);

        cyc(4);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
